pll_reset_sequencer: RTL and testbench

- Sequences the system PLL and the fabric reset tree.
- Pulses the PLL reset, waits for lock with a timeout, and debounces lock.
- Releases the synchronous system reset to the 100 MHz domain only after lock is stable.
- Re-sequences on lock loss or a software request. Runs from the free-running 50 MHz reference clock, upstream of the PLL.

---
 rtl/pll_reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL and fabric reset sequencer running from the free-running reference clock.
// Pulses the PLL reset, waits for lock within a timeout window, debounces the
// synchronized lock, then releases the system reset. Re-sequences when lock is
// lost or software asks for it, and parks the PLL in FAULT after repeated
// failed attempts.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 64,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Terminal counts are compared against the counter value of the final cycle.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    logic             r_lock_meta;
    logic             r_locked_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_retry;
    logic [7:0]       r_llc;
    logic             r_pll_rst;
    logic             r_sys_reset_n;
    logic             r_ready;
    logic             r_fault;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_retry_nxt;
    logic [1:0]       w_retry_inc;
    logic [7:0]       w_llc_nxt;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_locked_s  <= r_lock_meta;
        end
    end

    // Next-state, counter, retry and lock-loss decisions; soft_reset overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_retry_nxt = r_retry;
        w_llc_nxt   = r_llc;
        w_retry_inc = r_retry + 2'd1;
        if (soft_reset) begin
            w_state_nxt = ST_RST_PLL;
            w_retry_nxt = 2'd0;
        end else begin
            case (r_state)
                ST_RST_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RST_PLL;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // Any drop restarts the lock wait with a fresh timeout and no retry penalty.
                    if (!r_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = 2'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_locked_s) begin
                        w_state_nxt = ST_RST_PLL;
                        if (r_llc != 8'd255) begin
                            w_llc_nxt = r_llc + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_RST_PLL;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so they move on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_RST_PLL;
            r_cnt         <= '0;
            r_retry       <= 2'd0;
            r_llc         <= 8'd0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_ready       <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_retry       <= w_retry_nxt;
            r_llc         <= w_llc_nxt;
            r_pll_rst     <= (w_state_nxt == ST_RST_PLL) || (w_state_nxt == ST_FAULT);
            r_sys_reset_n <= (w_state_nxt == ST_RUN);
            r_ready       <= (w_state_nxt == ST_RUN);
            r_fault       <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pll_rst         = r_pll_rst;
    assign sys_reset_n     = r_sys_reset_n;
    assign ready           = r_ready;
    assign fault           = r_fault;
    assign retry_count     = r_retry;
    assign lock_loss_count = r_llc;
    assign state           = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Each step queues the expected output vector, advances one clock and
// compares the DUT outputs against the popped expectation.
module tb_pll_reset_sequencer;

    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int         checks;
    int         errors;
    logic [7:0] exp_llc;
    logic [16:0] exp_q[$];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES    (4),
        .LOCK_TIMEOUT      (20),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES       (2),
        .CNT_W             (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .soft_reset     (soft_reset),
        .pll_rst        (pll_rst),
        .sys_reset_n    (sys_reset_n),
        .ready          (ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected vector: {state, pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_count}
    function automatic logic [16:0] expect_vec(input logic [2:0] st, input logic [1:0] rc,
                                               input logic [7:0] llc);
        logic pr, srn, rdy, flt;
        pr  = (st == S_RST) || (st == S_FAULT);
        srn = (st == S_RUN);
        rdy = (st == S_RUN);
        flt = (st == S_FAULT);
        return {st, pr, srn, rdy, flt, rc, llc};
    endfunction

    task automatic chk(input logic [2:0] st, input logic [1:0] rc, input string tag);
        logic [16:0] exp_v;
        logic [16:0] obs_v;
        exp_q.push_back(expect_vec(st, rc, exp_llc));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {state, pll_rst, sys_reset_n, ready, fault, retry_count, lock_loss_count};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs_v, exp_v);
        end
    endtask

    task automatic chkn(input int n, input logic [2:0] st, input logic [1:0] rc, input string tag);
        for (int i = 0; i < n; i++) chk(st, rc, tag);
    endtask

    // From the first cycle of RST_PLL with lock already present: reach RUN.
    task automatic bring_up(input logic [1:0] rc, input string tag);
        chkn(3, S_RST, rc, tag);
        chk(S_WAIT, rc, tag);
        chkn(8, S_STABLE, rc, tag);
        chk(S_RUN, 2'd0, tag);
    endtask

    // Drop lock while in RUN, expect the re-sequence, then restore lock and return to RUN.
    task automatic lose_and_recover();
        pll_locked = 1'b0;
        chkn(2, S_RUN, 2'd0, "loss_sync");
        if (exp_llc != 8'd255) exp_llc = exp_llc + 8'd1;
        chk(S_RST, 2'd0, "loss_edge");
        pll_locked = 1'b1;
        bring_up(2'd0, "loss_rerun");
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_llc    = 8'd0;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        soft_reset = 1'b0;

        // Reset values
        chkn(3, S_RST, 2'd0, "reset");

        // Nominal bring-up: lock appears in cycle 10
        reset_n = 1'b1;
        chkn(3, S_RST, 2'd0, "nom_pllrst");
        chkn(7, S_WAIT, 2'd0, "nom_wait");
        pll_locked = 1'b1;
        chkn(2, S_WAIT, 2'd0, "nom_sync");
        chkn(8, S_STABLE, 2'd0, "nom_stable");
        chkn(3, S_RUN, 2'd0, "nom_run");

        // Lock loss in RUN, repeated until the counter saturates
        for (int i = 0; i < 257; i++) lose_and_recover();

        // Timeout on the first attempt, success on the second
        soft_reset = 1'b1;
        pll_locked = 1'b0;
        chk(S_RST, 2'd0, "to_soft");
        soft_reset = 1'b0;
        chkn(3, S_RST, 2'd0, "to_pllrst");
        chkn(20, S_WAIT, 2'd0, "to_wait");
        chk(S_RST, 2'd1, "to_retry");
        pll_locked = 1'b1;
        bring_up(2'd1, "to_second");

        // Two timeouts lead to FAULT, soft_reset recovers
        soft_reset = 1'b1;
        pll_locked = 1'b0;
        chk(S_RST, 2'd0, "flt_soft");
        soft_reset = 1'b0;
        chkn(3, S_RST, 2'd0, "flt_rst1");
        chkn(20, S_WAIT, 2'd0, "flt_wait1");
        chk(S_RST, 2'd1, "flt_retry1");
        chkn(3, S_RST, 2'd1, "flt_rst2");
        chkn(20, S_WAIT, 2'd1, "flt_wait2");
        chk(S_FAULT, 2'd2, "flt_enter");
        chkn(3, S_FAULT, 2'd2, "flt_hold");
        soft_reset = 1'b1;
        chk(S_RST, 2'd0, "flt_exit");
        soft_reset = 1'b0;

        // Stability debounce: a one-cycle lock drop in STABLE restarts the wait
        pll_locked = 1'b1;
        chkn(3, S_RST, 2'd0, "deb_rst");
        chk(S_WAIT, 2'd0, "deb_wait");
        chkn(5, S_STABLE, 2'd0, "deb_stable");
        pll_locked = 1'b0;
        chk(S_STABLE, 2'd0, "deb_glitch");
        pll_locked = 1'b1;
        chk(S_STABLE, 2'd0, "deb_glitch2");
        chk(S_WAIT, 2'd0, "deb_rewait");
        chkn(8, S_STABLE, 2'd0, "deb_clean");
        chk(S_RUN, 2'd0, "deb_run");

        // soft_reset colliding with the stable-complete edge, then held for several cycles
        soft_reset = 1'b1;
        chk(S_RST, 2'd0, "col_soft");
        soft_reset = 1'b0;
        chkn(3, S_RST, 2'd0, "col_rst");
        chk(S_WAIT, 2'd0, "col_wait");
        chkn(8, S_STABLE, 2'd0, "col_stable");
        soft_reset = 1'b1;
        chk(S_RST, 2'd0, "col_complete");
        chkn(2, S_RST, 2'd0, "col_held");
        soft_reset = 1'b0;
        chkn(3, S_RST, 2'd0, "col_release");
        chk(S_WAIT, 2'd0, "col_rewait");

        // reset_n mid-WAIT_LOCK clears everything, including the lock-loss count
        reset_n = 1'b0;
        exp_llc = 8'd0;
        chk(S_RST, 2'd0, "rst_mid");
        reset_n = 1'b1;
        bring_up(2'd0, "rst_rerun");
        chkn(2, S_RUN, 2'd0, "rst_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
